// File: rtl/control_pipe_pkg.sv
// control_pipe_pkg -- shared constants and types for the control_pipe slice.
//
// Holds the opcode and funct encodings, the shamt value that every legal
// R-type must carry, the alu_op encodings, and the bit positions of the
// fields inside the packed ctrl word.
//
// Packed ctrl word, LSB first:
//   [0]      mem_we
//   [2:1]    alu_op
//   [3]      mux_wb
//   [4]      mux_mul
//   [5]      mux_alu
//   [6]      rf_we
//   [7]      extend
//   [8]      mult
//   then rd, rt, rs (REG_AW bits each), then zero padding up to CTRL_W.
package control_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd5;
  localparam logic [5:0] OP_SW    = 6'd6;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_MUL = 6'd50;

  localparam logic [4:0] SHAMT_REQ = 5'd10;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam int OFF_MEM_WE  = 0;
  localparam int OFF_ALU_OP  = 1;
  localparam int OFF_MUX_WB  = 3;
  localparam int OFF_MUX_MUL = 4;
  localparam int OFF_MUX_ALU = 5;
  localparam int OFF_RF_WE   = 6;
  localparam int OFF_EXTEND  = 7;
  localparam int OFF_MULT    = 8;
  localparam int OFF_RD      = 9;
  localparam int FLAGS_W     = 9;

  // Register fields sit above rd; their offsets scale with the address width.
  function automatic int off_rt(input int reg_aw);
    return OFF_RD + reg_aw;
  endfunction

  function automatic int off_rs(input int reg_aw);
    return OFF_RD + 2 * reg_aw;
  endfunction

  // Member order mirrors the low FLAGS_W bits of the ctrl word exactly.
  typedef struct packed {
    logic    mult;
    logic    extend;
    logic    rf_we;
    logic    mux_alu;
    logic    mux_mul;
    logic    mux_wb;
    alu_op_e alu_op;
    logic    mem_we;
  } ctrl_flags_t;

endpackage

// File: rtl/control_decode.sv
// control_decode -- purely combinational instruction decoder.
//
// Ports:
//   instr      in   32      instruction word
//   ctrl_word  out  CTRL_W  packed control word (layout in control_pipe_pkg)
//   illegal    out  1       opcode/funct/shamt combination is undefined
//   is_lw      out  1       instruction is a load
//   is_mul     out  1       instruction is a legal MUL
//   uses_rs    out  1       instruction reads rs
//   uses_rt    out  1       instruction reads rt
//   rs, rt     out  REG_AW  source register fields
//
// Illegal instructions keep rs/rt for visibility but clear rd and every
// enable/mux/op field, and report no register reads.
module control_decode
  import control_pipe_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic              illegal,
  output logic              is_lw,
  output logic              is_mul,
  output logic              uses_rs,
  output logic              uses_rt,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt
);

  logic [5:0]        opcode;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rd;
  ctrl_flags_t       flags;
  logic              r_legal;
  alu_op_e           r_alu_op;

  assign opcode = instr[31:26];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign rs     = REG_AW'(instr[25:21]);
  assign rt     = REG_AW'(instr[20:16]);

  // funct table for R-type; shamt must also match for the instruction to be legal.
  always_comb begin
    r_legal  = (shamt == SHAMT_REQ);
    r_alu_op = ALU_ADD;
    case (funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_MUL:  r_alu_op = ALU_OR;
      default: r_legal  = 1'b0;
    endcase
  end

  always_comb begin
    flags   = '0;
    rd      = '0;
    illegal = 1'b0;
    is_lw   = 1'b0;
    is_mul  = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OP_LW: begin
        flags.extend = 1'b1;
        flags.rf_we  = 1'b1;
        flags.mux_wb = 1'b1;
        rd           = rt;
        is_lw        = 1'b1;
        uses_rs      = 1'b1;
      end
      OP_SW: begin
        flags.extend = 1'b1;
        flags.mux_wb = 1'b1;
        flags.mem_we = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      OP_RTYPE: begin
        if (r_legal) begin
          flags.rf_we   = 1'b1;
          flags.mux_alu = 1'b1;
          flags.alu_op  = r_alu_op;
          rd            = REG_AW'(instr[15:11]);
          uses_rs       = 1'b1;
          uses_rt       = 1'b1;
          if (funct == FN_MUL) begin
            flags.mult    = 1'b1;
            flags.mux_mul = 1'b1;
            is_mul        = 1'b1;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ctrl_word = CTRL_W'({rs, rt, rd, flags});

endmodule

// File: rtl/control_pipe.sv
// control_pipe -- one-stage decode pipeline with load-use and multiply stalls.
//
// Ports:
//   clk, rst     in   1       clock; synchronous active-high reset
//   instr_valid  in   1       instr carries an instruction
//   instr        in   32      instruction word
//   instr_ready  out  1       instruction accepted when high with instr_valid
//   ctrl_valid   out  1       ctrl holds a decoded instruction
//   ctrl_ready   in   1       downstream consumes ctrl this cycle
//   ctrl         out  CTRL_W  registered packed control word
//   illegal      out  1       instruction in ctrl was undefined
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once ctrl_valid is high it, ctrl and illegal hold until a
// cycle with ctrl_ready high; instr_valid/instr are expected to hold until
// instr_ready is seen.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int CTRL_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              dec_is_lw;
  logic              dec_is_mul;
  logic              dec_uses_rs;
  logic              dec_uses_rt;
  logic [REG_AW-1:0] dec_rs;
  logic [REG_AW-1:0] dec_rt;

  logic [CTRL_W-1:0] ctrl_q;
  logic              illegal_q;
  logic              valid_q;
  logic              lw_q;
  logic [REG_AW-1:0] lw_rd_q;
  logic [CNT_W-1:0]  mul_cnt;

  logic out_free;
  logic hazard;
  logic accept;

  control_decode #(
    .CTRL_W(CTRL_W),
    .REG_AW(REG_AW)
  ) u_decode (
    .instr     (instr),
    .ctrl_word (dec_ctrl),
    .illegal   (dec_illegal),
    .is_lw     (dec_is_lw),
    .is_mul    (dec_is_mul),
    .uses_rs   (dec_uses_rs),
    .uses_rt   (dec_uses_rt),
    .rs        (dec_rs),
    .rt        (dec_rt)
  );

  // The output register can take a new entry when empty or being drained.
  assign out_free = !valid_q || ctrl_ready;

  // A load sitting in the output register whose destination is read by the
  // incoming instruction: its data is not available yet, so hold one cycle.
  assign hazard = valid_q && lw_q && (lw_rd_q != '0) && instr_valid &&
                  ((dec_uses_rs && (dec_rs == lw_rd_q)) ||
                   (dec_uses_rt && (dec_rt == lw_rd_q)));

  assign instr_ready = !rst && out_free && (mul_cnt == '0) && !hazard;
  assign accept      = instr_valid && instr_ready;

  // When the register is free but nothing is accepted (idle or stall) it
  // loads a bubble; that is what produces the single load-use gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      lw_q      <= 1'b0;
      lw_rd_q   <= '0;
    end else if (out_free) begin
      valid_q   <= accept;
      ctrl_q    <= accept ? dec_ctrl : '0;
      illegal_q <= accept && dec_illegal;
      lw_q      <= accept && dec_is_lw;
      lw_rd_q   <= accept ? dec_rt : '0;
    end
  end

  // Multiplier occupancy counts down regardless of downstream backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt <= '0;
    end else if (accept && dec_is_mul) begin
      mul_cnt <= MUL_LOAD;
    end else if (mul_cnt != '0) begin
      mul_cnt <= mul_cnt - 1'b1;
    end
  end

  assign ctrl_valid = valid_q;
  assign ctrl       = ctrl_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_control_pipe.sv
module tb_control_pipe;

  localparam int CTRL_W  = 32;
  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 3;

  logic              clk;
  logic              rst;
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic              ctrl_valid;
  logic              ctrl_ready;
  logic [CTRL_W-1:0] ctrl;
  logic              illegal;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];

  control_pipe #(
    .CTRL_W (CTRL_W),
    .REG_AW (REG_AW),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .ctrl       (ctrl),
    .illegal    (illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int funct, input int shamt);
    return {6'd4, 5'(rs), 5'(rt), 5'(rd), 5'(shamt), 6'(funct)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt,
                                        input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // ---------------- reference model ----------------
  // Returns {illegal, ctrl} computed straight from the instruction-set rules.
  function automatic logic [32:0] ref_ctrl(input logic [31:0] w);
    int  op, fn, sh;
    bit  ill, ext, we, malu, mmul, wb, mw, mlt;
    int  alu, rd;
    op = int'(w[31:26]); fn = int'(w[5:0]); sh = int'(w[10:6]);
    ill = 1; ext = 0; we = 0; malu = 0; mmul = 0; wb = 0; mw = 0; mlt = 0;
    alu = 0; rd = 0;
    if (op == 5) begin
      ill = 0; ext = 1; we = 1; wb = 1; rd = int'(w[20:16]);
    end else if (op == 6) begin
      ill = 0; ext = 1; wb = 1; mw = 1;
    end else if (op == 4 && sh == 10 &&
                 (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 50)) begin
      ill = 0; we = 1; malu = 1; rd = int'(w[15:11]);
      alu = (fn == 32) ? 0 : (fn == 34) ? 1 : (fn == 36) ? 2 : 3;
      if (fn == 50) begin mlt = 1; mmul = 1; end
    end
    return {ill, 8'd0, w[25:21], w[20:16], 5'(rd), mlt, ext, we, malu, mmul, wb,
            2'(alu), mw};
  endfunction

  function automatic bit ref_is_mul(input logic [31:0] w);
    return w[31:26] == 6'd4 && w[10:6] == 5'd10 && w[5:0] == 6'd50;
  endfunction

  function automatic bit ref_reads(input logic [31:0] w, input logic [4:0] r);
    logic [32:0] c;
    c = ref_ctrl(w);
    if (c[32]) return 0;
    if (w[31:26] == 6'd5) return w[25:21] == r;
    return (w[25:21] == r) || (w[20:16] == r);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [31:0] w, input bit r);
    @(negedge clk);
    instr_valid = v;
    instr       = w;
    ctrl_ready  = r;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; instr_valid = 1; instr = rtype(1, 2, 3, 32, 10); ctrl_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ctrl_valid); end
    checks++;
    if (ctrl !== '0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst got=%b exp=0", instr_ready); end
    @(negedge clk);
    rst = 0; instr_valid = 0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", instr_ready); end
  endtask

  task automatic test_add();
    logic [31:0] add_w;
    add_w = rtype(1, 2, 3, 32, 10);
    drive(1, add_w, 1);
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL add_ready got=%b exp=1", instr_ready); end
    drive(0, '0, 1);
    checks++;
    if (ctrl_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", ctrl_valid); end
    checks++;
    if ({illegal, ctrl} !== ref_ctrl(add_w)) begin
      failures++; $display("FAIL add_ctrl got=%h exp=%h", {illegal, ctrl}, ref_ctrl(add_w));
    end
    checks++;
    if (ctrl[13:9] !== 5'd3 || ctrl[6] !== 1'b1 || ctrl[5] !== 1'b1 || ctrl[2:1] !== 2'b00) begin
      failures++; $display("FAIL add_fields got rd=%0d we=%b malu=%b alu=%b exp rd=3 we=1 malu=1 alu=00",
                           ctrl[13:9], ctrl[6], ctrl[5], ctrl[2:1]);
    end
    drive(0, '0, 1);
    checks++;
    if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", ctrl_valid); end
  endtask

  task automatic test_load_use();
    logic [31:0] lw_w, add_dep, add_ind;
    lw_w    = itype(5, 1, 4, 16);
    add_dep = rtype(4, 2, 6, 32, 10);
    add_ind = rtype(5, 2, 6, 34, 10);
    drive(1, lw_w, 1);
    drive(1, add_dep, 1);
    checks++;
    if (ctrl_valid !== 1'b1 || {illegal, ctrl} !== ref_ctrl(lw_w)) begin
      failures++; $display("FAIL lu_lw_out got v=%b c=%h exp v=1 c=%h", ctrl_valid, {illegal, ctrl}, ref_ctrl(lw_w));
    end
    checks++;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL lu_hazard_ready got=%b exp=0", instr_ready); end
    drive(1, add_dep, 1);
    checks++;
    if (ctrl_valid !== 1'b0 || instr_ready !== 1'b1) begin
      failures++; $display("FAIL lu_bubble got v=%b rdy=%b exp v=0 rdy=1", ctrl_valid, instr_ready);
    end
    drive(0, '0, 1);
    checks++;
    if (ctrl_valid !== 1'b1 || {illegal, ctrl} !== ref_ctrl(add_dep)) begin
      failures++; $display("FAIL lu_add_out got v=%b c=%h exp v=1 c=%h", ctrl_valid, {illegal, ctrl}, ref_ctrl(add_dep));
    end
    drive(1, lw_w, 1);
    drive(1, add_ind, 1);
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL lu_nohaz_ready got=%b exp=1", instr_ready); end
    drive(0, '0, 1);
    checks++;
    if (ctrl_valid !== 1'b1 || {illegal, ctrl} !== ref_ctrl(add_ind)) begin
      failures++; $display("FAIL lu_nohaz_out got v=%b c=%h exp v=1 c=%h", ctrl_valid, {illegal, ctrl}, ref_ctrl(add_ind));
    end
    drive(0, '0, 1);
  endtask

  task automatic test_mul();
    logic [31:0] mul_w, add_w;
    mul_w = rtype(7, 8, 9, 50, 10);
    add_w = rtype(1, 2, 3, 36, 10);
    drive(1, mul_w, 1);
    drive(1, add_w, 1);
    checks++;
    if (ctrl_valid !== 1'b1 || {illegal, ctrl} !== ref_ctrl(mul_w)) begin
      failures++; $display("FAIL mul_out got v=%b c=%h exp v=1 c=%h", ctrl_valid, {illegal, ctrl}, ref_ctrl(mul_w));
    end
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      if (i > 0) drive(1, add_w, 1);
      checks++;
      if (instr_ready !== 1'b0) begin failures++; $display("FAIL mul_stall%0d got=%b exp=0", i, instr_ready); end
    end
    drive(1, add_w, 1);
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL mul_resume got=%b exp=1", instr_ready); end
    drive(0, '0, 1);
    checks++;
    if (ctrl_valid !== 1'b1 || {illegal, ctrl} !== ref_ctrl(add_w)) begin
      failures++; $display("FAIL mul_add_out got v=%b c=%h exp v=1 c=%h", ctrl_valid, {illegal, ctrl}, ref_ctrl(add_w));
    end
    drive(0, '0, 1);
  endtask

  task automatic test_backpressure();
    logic [31:0] sw_w, add_w;
    sw_w  = itype(6, 3, 4, 8);
    add_w = rtype(1, 2, 5, 37, 10);
    drive(1, sw_w, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, add_w, 0);
      checks++;
      if (ctrl_valid !== 1'b1 || {illegal, ctrl} !== ref_ctrl(sw_w) || ctrl[0] !== 1'b1 ||
          instr_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got v=%b c=%h rdy=%b exp v=1 c=%h rdy=0",
                             i, ctrl_valid, {illegal, ctrl}, instr_ready, ref_ctrl(sw_w));
      end
    end
    drive(1, add_w, 1);
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", instr_ready); end
    drive(0, '0, 1);
    checks++;
    if (ctrl_valid !== 1'b1 || {illegal, ctrl} !== ref_ctrl(add_w)) begin
      failures++; $display("FAIL bp_next got v=%b c=%h exp v=1 c=%h", ctrl_valid, {illegal, ctrl}, ref_ctrl(add_w));
    end
    drive(0, '0, 1);
  endtask

  task automatic test_illegal();
    logic [31:0] ill_w[3];
    ill_w[0] = itype(7, 1, 2, 3);
    ill_w[1] = rtype(1, 2, 3, 33, 10);
    ill_w[2] = rtype(1, 2, 3, 32, 9);
    drive(1, ill_w[0], 1);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1, ill_w[i+1], 1);
      else drive(0, '0, 1);
      checks++;
      if (ctrl_valid !== 1'b1 || illegal !== 1'b1 || ctrl[6] !== 1'b0 || ctrl[0] !== 1'b0 ||
          {illegal, ctrl} !== ref_ctrl(ill_w[i])) begin
        failures++; $display("FAIL illegal%0d got v=%b c=%h exp v=1 c=%h", i, ctrl_valid,
                             {illegal, ctrl}, ref_ctrl(ill_w[i]));
      end
    end
    drive(0, '0, 1);
  endtask

  task automatic test_reset_in_mul();
    logic [31:0] mul_w, add_w;
    mul_w = rtype(1, 2, 3, 50, 10);
    add_w = rtype(4, 5, 6, 32, 10);
    drive(1, mul_w, 1);
    @(negedge clk);
    rst = 1; instr_valid = 1; instr = add_w;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL rstmul_valid got=%b exp=0", ctrl_valid); end
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL rstmul_ready got=%b exp=1", instr_ready); end
    drive(0, '0, 1);
    checks++;
    if (ctrl_valid !== 1'b1 || {illegal, ctrl} !== ref_ctrl(add_w)) begin
      failures++; $display("FAIL rstmul_add got v=%b c=%h exp v=1 c=%h", ctrl_valid, {illegal, ctrl}, ref_ctrl(add_w));
    end
    drive(0, '0, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    int sel, fn, sh;
    int fns[5] = '{32, 34, 36, 37, 50};
    sel = $urandom_range(0, 9);
    if (sel <= 2) return itype(5, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 65535));
    if (sel <= 4) return itype(6, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 65535));
    if (sel <= 8) begin
      fn = fns[$urandom_range(0, 4)];
      sh = ($urandom_range(0, 9) == 0) ? 3 : 10;
      return rtype($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 31), fn, sh);
    end
    return itype(8 + $urandom_range(0, 55), $urandom_range(0, 5), $urandom_range(0, 5), 0);
  endfunction

  // Cycle-level model: what sits in the output register, whether it is
  // valid, and how many cycles the multiplier remains busy.
  task automatic test_random();
    bit          m_valid, out_free, haz, exp_ready, acc;
    logic [31:0] m_instr;
    int          m_mul;
    logic [32:0] exp_c;
    @(negedge clk);
    rst = 1; instr_valid = 0; ctrl_ready = 1;
    @(negedge clk);
    rst = 0;
    m_valid = 0; m_instr = '0; m_mul = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 390) begin
        instr_valid = ($urandom_range(0, 4) != 0);
        instr       = rand_instr();
        ctrl_ready  = ($urandom_range(0, 3) != 0);
      end else begin
        instr_valid = 0;
        ctrl_ready  = 1;
      end
      #1;
      out_free  = !m_valid || ctrl_ready;
      haz       = m_valid && (m_instr[31:26] == 6'd5) && (m_instr[20:16] != 5'd0) &&
                  instr_valid && ref_reads(instr, m_instr[20:16]);
      exp_ready = out_free && (m_mul == 0) && !haz;
      checks++;
      if (ctrl_valid !== m_valid) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, ctrl_valid, m_valid);
      end
      checks++;
      if (instr_ready !== exp_ready) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, instr_ready, exp_ready);
      end
      if (ctrl_valid === 1'b1 && ctrl_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_unexpected cyc=%0d got=%h exp=none", cyc, {illegal, ctrl});
        end else begin
          exp_c = exp_q.pop_front();
          if ({illegal, ctrl} !== exp_c) begin
            failures++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", cyc, {illegal, ctrl}, exp_c);
          end
        end
      end
      acc = instr_valid && exp_ready;
      if (acc) exp_q.push_back(ref_ctrl(instr));
      if (out_free) begin
        m_valid = acc;
        if (acc) m_instr = instr;
      end
      if (acc && ref_is_mul(instr)) m_mul = MUL_LAT - 1;
      else if (m_mul > 0) m_mul--;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rnd_drain got=%0d pending exp=0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1; instr_valid = 0; instr = '0; ctrl_ready = 1;
    test_reset();
    test_add();
    test_load_use();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset_in_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameter CTRL_W, default 32, width of packed control word (at least 3*REG_AW+9).
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter MUL_LAT, default 3, multiplier occupancy in cycles, minimum 1.
REQ-004 SHALL have port clk, input, 1, single clock for all state.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port instr_valid, input, 1, instr carries a valid instruction.
REQ-007 SHALL have port instr, input, 32, instruction word.
REQ-008 SHALL have port instr_ready, output, 1, instruction accepted this cycle when high with instr_valid.
REQ-009 SHALL have port ctrl_valid, output, 1, ctrl holds a decoded instruction.
REQ-010 SHALL have port ctrl_ready, input, 1, downstream consumes ctrl this cycle.
REQ-011 SHALL have port ctrl, output, CTRL_W, packed {zero pad, rs, rt, rd, mult, extend, rf_we, mux_alu, mux_mul, mux_wb, alu_op[1:0], mem_we}.
REQ-012 SHALL have port illegal, output, 1, the instruction in ctrl has an undefined opcode/funct.

Function
REQ-013 SHALL decode opcode instr[31:26]: 5 = LW, 6 = SW, 4 = R-type; all other opcodes illegal.
REQ-014 LW SHALL produce extend=1, rf_we=1, mux_alu=0, mux_wb=1, alu_op=00, mem_we=0, rd=instr[20:16].
REQ-015 SW SHALL produce extend=1, rf_we=0, mux_wb=1, alu_op=00, mem_we=1, rd=0.
REQ-016 R-type SHALL require shamt instr[10:6]=10; funct 32/34/36/37 gives alu_op 00/01/10/11, and funct 50 gives MUL with alu_op=11, mult=1, mux_mul=1.
REQ-017 Every valid R-type SHALL produce rf_we=1, mux_alu=1, mux_wb=0, extend=0, rd=instr[15:11]; rs=instr[25:21] and rt=instr[20:16] for all opcodes.
REQ-018 An illegal instruction SHALL be accepted and emitted with illegal=1 and all enable/mux/op fields 0.
REQ-019 Output SHALL be registered: an instruction accepted in cycle N appears on ctrl/ctrl_valid in cycle N+1.
REQ-020 While ctrl_valid=1 and ctrl_ready=0, ctrl, illegal and ctrl_valid SHALL hold stable.
REQ-021 instr_ready SHALL be 1 only when (ctrl_valid=0 or ctrl_ready=1), the multiply counter is 0, and no load-use hazard exists.
REQ-022 A load-use hazard SHALL exist when ctrl_valid=1, ctrl holds an LW with rd!=0, and the incoming valid instruction reads that rd (LW: rs; SW and R-type: rs or rt).
REQ-023 On a hazard with ctrl_ready=1, the output register SHALL load a bubble (ctrl_valid=0), giving exactly one bubble cycle; the instruction SHALL be accepted the following cycle.
REQ-024 Accepting a MUL SHALL load the multiply counter with MUL_LAT-1, decremented every cycle until 0, independent of ctrl_ready; MUL_LAT=1 SHALL cause no stall.
REQ-025 With instr_valid=0 and ctrl_ready=1, ctrl_valid SHALL go 0 next cycle.
REQ-026 A hazard and a non-zero multiply counter in the same cycle SHALL both block acceptance; acceptance resumes only when both have cleared.

Reset
REQ-027 When rst=1 at a clock edge: ctrl_valid=0, ctrl=0, illegal=0, multiply counter=0; the in-flight instruction is discarded.
REQ-028 instr_ready SHALL be 0 while rst=1 and SHALL depend only on REQ-021 from the first cycle after reset.

Structure
REQ-029 A shared package SHALL hold opcode constants (LW, SW, RTYPE), funct constants, the required shamt value, the alu_op encodings and the ctrl field-position offsets.
REQ-030 The combinational decode SHALL be a sub-module named control_decode; control_pipe SHALL contain the handshake, hazard and counter logic.

Verification
REQ-031 Reset, then ADD (op 4, rs 1, rt 2, rd 3, shamt 10, funct 32) with ctrl_ready=1 -> next cycle ctrl_valid=1, rd=3, rf_we=1, mux_alu=1, alu_op=00.
REQ-032 LW rt=4 followed by ADD rs=4 -> one ctrl_valid=0 cycle between them; LW followed by ADD rs=5 -> no bubble.
REQ-033 MUL with MUL_LAT=3 followed by ADD -> instr_ready low for 2 cycles after the MUL is accepted; ADD appears 3 cycles after MUL.
REQ-034 ctrl_ready=0 for 4 cycles with SW pending -> ctrl held constant with mem_we=1, instr_ready=0 throughout.
REQ-035 opcode 7, and R-type with funct 33 -> emitted with illegal=1, rf_we=0, mem_we=0.
REQ-036 rst asserted during the MUL stall -> next cycle ctrl_valid=0, counter 0, instr_ready=1 after rst drops.
